// File: rtl/msrv32_trap_ctrl.sv
// Machine-mode trap sequencer. Watches decoded exception flags and the CSR
// interrupt enable/pending bits. Drives the mepc/mcause/mstatus.MIE update
// strobes, the retire pulse and the fetch-stage PC source select.
module msrv32_trap_ctrl #(
   parameter int unsigned IRQ_EN       = 1,
   parameter int unsigned RESET_CYCLES = 2
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       illegal_instr_in,
   input  logic       misaligned_instr_in,
   input  logic       misaligned_load_in,
   input  logic       misaligned_store_in,
   input  logic       ecall_in,
   input  logic       ebreak_in,
   input  logic       mret_in,
   input  logic       mie_in,
   input  logic       meie_in,
   input  logic       mtie_in,
   input  logic       msie_in,
   input  logic       meip_in,
   input  logic       mtip_in,
   input  logic       msip_in,
   output logic       set_epc_out,
   output logic       set_cause_out,
   output logic       i_or_e_out,
   output logic [3:0] cause_out,
   output logic       mie_clear_out,
   output logic       mie_set_out,
   output logic       instret_inc_out,
   output logic       misaligned_exception_out,
   output logic [1:0] pc_src_out,
   output logic       flush_out
);

   localparam logic [1:0] StReset      = 2'd0;
   localparam logic [1:0] StOperating  = 2'd1;
   localparam logic [1:0] StTrapTaken  = 2'd2;
   localparam logic [1:0] StTrapReturn = 2'd3;

   localparam int unsigned        CntW    = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [CntW-1:0]    CntLast = CntW'(RESET_CYCLES - 1);
   localparam logic               IrqOn   = (IRQ_EN != 0);

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] rst_cnt_q, rst_cnt_d;
   logic [3:0]      cause_q, cause_d;
   logic            i_or_e_q, i_or_e_d;

   logic            exc, irq, misaligned_any;
   logic [3:0]      exc_cause, irq_cause;

   // Exception/interrupt detection and cause encoding, highest priority first
   always_comb begin
      misaligned_any = misaligned_instr_in | misaligned_load_in | misaligned_store_in;
      exc = illegal_instr_in | misaligned_any | ecall_in | ebreak_in;
      irq = IrqOn & mie_in & ((meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in));

      if (misaligned_instr_in)     exc_cause = 4'd0;
      else if (illegal_instr_in)   exc_cause = 4'd2;
      else if (ebreak_in)          exc_cause = 4'd3;
      else if (ecall_in)           exc_cause = 4'd11;
      else if (misaligned_load_in) exc_cause = 4'd4;
      else                         exc_cause = 4'd6;

      if (meie_in & meip_in)       irq_cause = 4'd11;
      else if (msie_in & msip_in)  irq_cause = 4'd3;
      else                         irq_cause = 4'd7;
   end

   // Next-state, reset counter and cause capture
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cause_d   = cause_q;
      i_or_e_d  = i_or_e_q;
      case (state_q)
         StReset: begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == CntLast) begin
               state_d = StOperating;
            end
         end
         StOperating: begin
            // Exception beats a concurrent interrupt (which stays pending) and mret
            if (exc) begin
               cause_d  = exc_cause;
               i_or_e_d = 1'b0;
               state_d  = StTrapTaken;
            end else if (irq) begin
               cause_d  = irq_cause;
               i_or_e_d = 1'b1;
               state_d  = StTrapTaken;
            end else if (mret_in) begin
               state_d = StTrapReturn;
            end
         end
         default: state_d = StOperating;
      endcase
   end

   // State registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= StReset;
         rst_cnt_q <= '0;
         cause_q   <= 4'd0;
         i_or_e_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cause_q   <= cause_d;
         i_or_e_q  <= i_or_e_d;
      end
   end

   // Outputs: Moore on state, except retire and misaligned which follow inputs in OPERATING
   always_comb begin
      set_epc_out              = 1'b0;
      set_cause_out            = 1'b0;
      mie_clear_out            = 1'b0;
      mie_set_out              = 1'b0;
      instret_inc_out          = 1'b0;
      misaligned_exception_out = 1'b0;
      pc_src_out               = 2'b00;
      flush_out                = 1'b1;
      cause_out                = cause_q;
      i_or_e_out               = i_or_e_q;
      case (state_q)
         StReset: begin
            pc_src_out = 2'b00;
            flush_out  = 1'b1;
         end
         StOperating: begin
            pc_src_out               = 2'b01;
            flush_out                = 1'b0;
            instret_inc_out          = ~exc & ~irq;
            misaligned_exception_out = misaligned_any;
         end
         StTrapTaken: begin
            set_epc_out   = 1'b1;
            set_cause_out = 1'b1;
            mie_clear_out = 1'b1;
            pc_src_out    = 2'b11;
            flush_out     = 1'b1;
         end
         default: begin
            mie_set_out = 1'b1;
            pc_src_out  = 2'b10;
            flush_out   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_msrv32_trap_ctrl.sv
// Scoreboard bench for msrv32_trap_ctrl: the stimulus process queues the
// expected output vector for each cycle, a negedge monitor pops and compares.
module tb_msrv32_trap_ctrl;

   typedef struct packed {
      logic [1:0] pc_src;
      logic       flush;
      logic       set_epc;
      logic       set_cause;
      logic       mie_clear;
      logic       mie_set;
      logic       instret;
      logic       misal;
      logic       ioe;
      logic [3:0] cause;
   } exp_t;

   typedef struct {
      string name;
      exp_t  e;
      bit    chk0;
      exp_t  e0;
   } item_t;

   localparam logic [13:0] ILL    = 14'h2000;
   localparam logic [13:0] MIS_I  = 14'h1000;
   localparam logic [13:0] MIS_L  = 14'h0800;
   localparam logic [13:0] MIS_S  = 14'h0400;
   localparam logic [13:0] ECALL  = 14'h0200;
   localparam logic [13:0] EBREAK = 14'h0100;
   localparam logic [13:0] MRET   = 14'h0080;
   localparam logic [13:0] MIE    = 14'h0040;
   localparam logic [13:0] MEIE   = 14'h0020;
   localparam logic [13:0] MTIE   = 14'h0010;
   localparam logic [13:0] MSIE   = 14'h0008;
   localparam logic [13:0] MEIP   = 14'h0004;
   localparam logic [13:0] MTIP   = 14'h0002;
   localparam logic [13:0] MSIP   = 14'h0001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [13:0] iv = '0;

   logic       set_epc, set_cause, ioe, mie_clear, mie_set, instret, misal, flush;
   logic [3:0] cause;
   logic [1:0] pc_src;
   logic       set_epc0, set_cause0, ioe0, mie_clear0, mie_set0, instret0, misal0, flush0;
   logic [3:0] cause0;
   logic [1:0] pc_src0;

   item_t q[$];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   msrv32_trap_ctrl #(.IRQ_EN(1), .RESET_CYCLES(2)) dut (
      .clk_in(clk), .rst_in(rst),
      .illegal_instr_in(iv[13]), .misaligned_instr_in(iv[12]),
      .misaligned_load_in(iv[11]), .misaligned_store_in(iv[10]),
      .ecall_in(iv[9]), .ebreak_in(iv[8]), .mret_in(iv[7]), .mie_in(iv[6]),
      .meie_in(iv[5]), .mtie_in(iv[4]), .msie_in(iv[3]),
      .meip_in(iv[2]), .mtip_in(iv[1]), .msip_in(iv[0]),
      .set_epc_out(set_epc), .set_cause_out(set_cause), .i_or_e_out(ioe),
      .cause_out(cause), .mie_clear_out(mie_clear), .mie_set_out(mie_set),
      .instret_inc_out(instret), .misaligned_exception_out(misal),
      .pc_src_out(pc_src), .flush_out(flush)
   );

   msrv32_trap_ctrl #(.IRQ_EN(0), .RESET_CYCLES(2)) dut0 (
      .clk_in(clk), .rst_in(rst),
      .illegal_instr_in(iv[13]), .misaligned_instr_in(iv[12]),
      .misaligned_load_in(iv[11]), .misaligned_store_in(iv[10]),
      .ecall_in(iv[9]), .ebreak_in(iv[8]), .mret_in(iv[7]), .mie_in(iv[6]),
      .meie_in(iv[5]), .mtie_in(iv[4]), .msie_in(iv[3]),
      .meip_in(iv[2]), .mtip_in(iv[1]), .msip_in(iv[0]),
      .set_epc_out(set_epc0), .set_cause_out(set_cause0), .i_or_e_out(ioe0),
      .cause_out(cause0), .mie_clear_out(mie_clear0), .mie_set_out(mie_set0),
      .instret_inc_out(instret0), .misaligned_exception_out(misal0),
      .pc_src_out(pc_src0), .flush_out(flush0)
   );

   function automatic exp_t e_rst();
      exp_t e = '0;
      e.flush = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_op(logic ir, logic ms, logic io, logic [3:0] c);
      exp_t e = '0;
      e.pc_src = 2'b01; e.instret = ir; e.misal = ms; e.ioe = io; e.cause = c;
      return e;
   endfunction

   function automatic exp_t e_take(logic io, logic [3:0] c);
      exp_t e = '0;
      e.pc_src = 2'b11; e.flush = 1'b1; e.set_epc = 1'b1; e.set_cause = 1'b1;
      e.mie_clear = 1'b1; e.ioe = io; e.cause = c;
      return e;
   endfunction

   function automatic exp_t e_ret(logic io, logic [3:0] c);
      exp_t e = '0;
      e.pc_src = 2'b10; e.flush = 1'b1; e.mie_set = 1'b1; e.ioe = io; e.cause = c;
      return e;
   endfunction

   // One cycle of stimulus: drive just after the edge, queue what the outputs must be
   task automatic cyc(input string name, input logic r, input logic [13:0] v, input exp_t e);
      item_t it;
      @(posedge clk);
      #1;
      rst = r;
      iv  = v;
      it.name = name; it.e = e; it.chk0 = 1'b0; it.e0 = '0;
      q.push_back(it);
   endtask

   task automatic cyc2(input string name, input logic [13:0] v, input exp_t e, input exp_t e0);
      item_t it;
      @(posedge clk);
      #1;
      rst = 1'b0;
      iv  = v;
      it.name = name; it.e = e; it.chk0 = 1'b1; it.e0 = e0;
      q.push_back(it);
   endtask

   // Monitor: compare the presented outputs against the oldest queued expectation
   always @(negedge clk) begin
      if (q.size() > 0) begin
         item_t it;
         exp_t  got, got0;
         it   = q.pop_front();
         got  = {pc_src, flush, set_epc, set_cause, mie_clear, mie_set, instret, misal, ioe, cause};
         got0 = {pc_src0, flush0, set_epc0, set_cause0, mie_clear0, mie_set0, instret0, misal0,
                 ioe0, cause0};
         vectors++;
         if (got !== it.e) begin
            miscompares++;
            $display("FAIL %s: got=%h exp=%h (pc_src,flush,epc,scause,mclr,mset,iret,mis,ioe,cause)",
                     it.name, got, it.e);
         end
         if (it.chk0) begin
            vectors++;
            if (got0 !== it.e0) begin
               miscompares++;
               $display("FAIL %s irq_en0: got=%h exp=%h", it.name, got0, it.e0);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset and release: two RESET cycles after release, then normal fetch
      cyc("rst_hold",     1'b1, '0, e_rst());
      cyc("rst_rel1",     1'b0, '0, e_rst());
      cyc("rst_rel2",     1'b0, '0, e_rst());
      cyc("op_idle",      1'b0, '0, e_op(1, 0, 0, 4'd0));
      // Illegal instruction
      cyc("illegal",      1'b0, ILL, e_op(0, 0, 0, 4'd0));
      cyc("illegal_take", 1'b0, '0,  e_take(0, 4'd2));
      cyc("after_take",   1'b0, '0,  e_op(1, 0, 0, 4'd2));
      // External + timer interrupt, then MIE cleared
      cyc("irq_ext",      1'b0, MIE|MEIE|MEIP|MTIE|MTIP, e_op(0, 0, 0, 4'd2));
      cyc("irq_ext_take", 1'b0, MEIE|MEIP|MTIE|MTIP,     e_take(1, 4'd11));
      cyc("irq_masked",   1'b0, MEIE|MEIP|MTIE|MTIP,     e_op(1, 0, 1, 4'd11));
      // ECALL beats a pending interrupt; the interrupt follows the mret
      cyc("ecall_irq",    1'b0, ECALL|MIE|MEIE|MEIP, e_op(0, 0, 1, 4'd11));
      cyc("ecall_take",   1'b0, MEIE|MEIP,           e_take(0, 4'd11));
      cyc("mret",         1'b0, MRET|MEIE|MEIP,      e_op(1, 0, 0, 4'd11));
      cyc("mret_ret",     1'b0, MIE|MEIE|MEIP,       e_ret(0, 4'd11));
      cyc("irq_after",    1'b0, MIE|MEIE|MEIP,       e_op(0, 0, 0, 4'd11));
      cyc("irq_aft_take", 1'b0, '0,                  e_take(1, 4'd11));
      cyc("op_idle2",     1'b0, '0,                  e_op(1, 0, 1, 4'd11));
      // Exception priority ladder
      cyc("pri_misi",     1'b0, MIS_I|ILL|EBREAK,        e_op(0, 1, 1, 4'd11));
      cyc("pri_misi_t",   1'b0, '0,                      e_take(0, 4'd0));
      cyc("pri_ill",      1'b0, ILL|EBREAK|ECALL|MIS_L,  e_op(0, 1, 0, 4'd0));
      cyc("pri_ill_t",    1'b0, '0,                      e_take(0, 4'd2));
      cyc("pri_ebrk",     1'b0, EBREAK|ECALL|MIS_S,      e_op(0, 1, 0, 4'd2));
      cyc("pri_ebrk_t",   1'b0, '0,                      e_take(0, 4'd3));
      cyc("pri_misl",     1'b0, MIS_L|MIS_S,             e_op(0, 1, 0, 4'd3));
      cyc("pri_misl_t",   1'b0, '0,                      e_take(0, 4'd4));
      cyc("pri_miss",     1'b0, MIS_S,                   e_op(0, 1, 0, 4'd4));
      cyc("pri_miss_t",   1'b0, '0,                      e_take(0, 4'd6));
      cyc("pri_ecall",    1'b0, ECALL|MIS_L,             e_op(0, 1, 0, 4'd6));
      cyc("pri_ecall_t",  1'b0, '0,                      e_take(0, 4'd11));
      // Interrupt priority and enable/pending pairing
      cyc("irq_sw",       1'b0, MIE|MSIE|MSIP|MTIE|MTIP, e_op(0, 0, 0, 4'd11));
      cyc("irq_sw_t",     1'b0, '0,                      e_take(1, 4'd3));
      cyc("irq_tmr",      1'b0, MIE|MTIE|MTIP,           e_op(0, 0, 1, 4'd3));
      cyc("irq_tmr_t",    1'b0, '0,                      e_take(1, 4'd7));
      cyc("irq_unpaired", 1'b0, MIE|MEIE|MSIP|MTIP,      e_op(1, 0, 1, 4'd7));
      // Exception beats mret
      cyc("mret_ill",     1'b0, MRET|ILL,                e_op(0, 0, 1, 4'd7));
      cyc("mret_ill_t",   1'b0, '0,                      e_take(0, 4'd2));
      cyc("op_idle3",     1'b0, '0,                      e_op(1, 0, 0, 4'd2));
      // Reset asserted while in TRAP_TAKEN
      cyc("pre_rst_ill",  1'b0, ILL,                     e_op(0, 0, 0, 4'd2));
      cyc("rst_in_trap",  1'b1, '0,                      e_rst());
      cyc("rst2_rel1",    1'b0, '0,                      e_rst());
      cyc("rst2_rel2",    1'b0, '0,                      e_rst());
      // IRQ_EN=0 instance ignores interrupts
      cyc2("both_idle",   '0,            e_op(1, 0, 0, 4'd0), e_op(1, 0, 0, 4'd0));
      cyc2("irq_en0",     MIE|MEIE|MEIP, e_op(0, 0, 0, 4'd0), e_op(1, 0, 0, 4'd0));
      cyc2("irq_en0_t",   MIE|MEIE|MEIP, e_take(1, 4'd11),    e_op(1, 0, 0, 4'd0));
      cyc2("irq_en0_end", '0,            e_op(1, 0, 1, 4'd11), e_op(1, 0, 0, 4'd0));

      repeat (2) @(posedge clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got=%0d queued exp=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
